// File: rtl/uart_transmit_pkg.sv
// Shared UART constants: FSM state encodings, data width and divider width.
// The receiver imports the same package so both sides agree on encodings.
package uart_transmit_pkg;

   localparam int DATA_W = 8;
   localparam int DIV_W  = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_e;

   // A divider of zero would mean "no cycles per bit"; run it as one.
   function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] div);
      return (div == '0) ? {{(DIV_W-1){1'b0}}, 1'b1} : div;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead FIFO holding bytes waiting for the transmitter.
// Full/empty are registered from the next count, so they are valid in the
// cycle after the push/pop that changes them. A push while full is dropped
// and reported with a one-cycle overflow pulse on the following cycle.
module uart_tx_fifo
   import uart_transmit_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              push_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] data_o,
   output logic              full_o,
   output logic              empty_o,
   output logic              overflow_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q;
   logic [AW-1:0]     rd_ptr_q;
   logic [CW-1:0]     count_q;
   logic [CW-1:0]     count_d;
   logic              full_q;
   logic              empty_q;
   logic              ovf_q;
   logic              push_ok;
   logic              pop_ok;

   // Full is judged on the registered flag: a same-cycle pop never makes room.
   assign push_ok = push_i & ~full_q;
   assign pop_ok  = pop_i & ~empty_q;

   // Next occupancy; simultaneous push and pop leave it unchanged.
   always_comb begin
      count_d = count_q;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointers, occupancy and registered status flags.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         ovf_q    <= 1'b0;
      end else begin
         count_q <= count_d;
         full_q  <= (count_d == CW'(DEPTH));
         empty_q <= (count_d == '0);
         ovf_q   <= push_i & full_q;
         if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
   end

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= data_i;
   end

   assign data_o     = mem_q[rd_ptr_q];
   assign full_o     = full_q;
   assign empty_o    = empty_q;
   assign overflow_o = ovf_q;

endmodule

// File: rtl/uart_transmit.sv
// 8N1 UART transmitter fed from a byte FIFO. Each frame is a start bit,
// eight data bits LSB first and a stop bit, each lasting div_q cycles where
// div_q is the effective clk_div latched at the moment the byte is popped.
// All outputs are registered from next-state values, so tx changes on the
// same edge as the state that drives it.
module uart_transmit
   import uart_transmit_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DIV_W-1:0]  clk_div,
   input  logic              i_tx_valid,
   input  logic [DATA_W-1:0] tx_data,
   output logic              tx,
   output logic              busy,
   output logic              irq,
   output logic              o_tx_full,
   output logic              o_tx_empty,
   output logic              o_tx_overflow
);

   tx_state_e         state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [DIV_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        bit_q, bit_d;
   logic              tx_q, tx_d;
   logic              busy_q, busy_d;
   logic              irq_q, irq_d;
   logic              pop;
   logic              bit_end;
   logic              fifo_empty;
   logic              fifo_full;
   logic [DATA_W-1:0] fifo_data;

   uart_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i      (clk),
      .rst_i      (rst),
      .push_i     (i_tx_valid),
      .data_i     (tx_data),
      .pop_i      (pop),
      .data_o     (fifo_data),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .overflow_o (o_tx_overflow)
   );

   // Last cycle of the current bit period.
   assign bit_end = (cnt_q == div_q - DIV_W'(1));

   // Next-state, datapath and registered-output decode.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      div_d   = div_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      irq_d   = 1'b0;
      pop     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = fifo_data;
               div_d   = eff_div(clk_div);
               cnt_d   = '0;
               bit_d   = '0;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (bit_end) begin
               cnt_d   = '0;
               state_d = ST_DATA;
            end else begin
               cnt_d = cnt_q + DIV_W'(1);
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               cnt_d   = '0;
               shift_d = shift_q >> 1;
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = ST_STOP;
            end else begin
               cnt_d = cnt_q + DIV_W'(1);
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               cnt_d = '0;
               if (!fifo_empty) begin
                  // Chain straight into the next frame with no idle gap.
                  pop     = 1'b1;
                  shift_d = fifo_data;
                  div_d   = eff_div(clk_div);
                  bit_d   = '0;
                  state_d = ST_START;
               end else begin
                  irq_d   = 1'b1;
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q + DIV_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
      tx_d   = (state_d == ST_DATA) ? shift_d[0] : (state_d != ST_START);
      busy_d = (state_d != ST_IDLE);
   end

   // State, counters, shift register and registered line outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         shift_q <= '0;
         div_q   <= DIV_W'(1);
         cnt_q   <= '0;
         bit_q   <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         irq_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         irq_q   <= irq_d;
      end
   end

   assign tx         = tx_q;
   assign busy       = busy_q;
   assign irq        = irq_q;
   assign o_tx_full  = fifo_full;
   assign o_tx_empty = fifo_empty;

endmodule

// File: tb/tb_uart_transmit.sv
// Bench for uart_transmit. A line-level reference model expands each popped
// byte into its 10 x div expected tx samples and predicts FIFO flags, irq and
// overflow every cycle; directed steps add frame-length and pulse counts.
module tb_uart_transmit;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] clk_div = 32'd4;
   logic        i_tx_valid = 1'b0;
   logic [7:0]  tx_data = 8'h00;
   logic        tx, busy, irq, o_tx_full, o_tx_empty, o_tx_overflow;

   // Clock
   always #5 clk = ~clk;

   uart_transmit #(.DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst           (rst),
      .clk_div       (clk_div),
      .i_tx_valid    (i_tx_valid),
      .tx_data       (tx_data),
      .tx            (tx),
      .busy          (busy),
      .irq           (irq),
      .o_tx_full     (o_tx_full),
      .o_tx_empty    (o_tx_empty),
      .o_tx_overflow (o_tx_overflow)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   logic [7:0] exp_q[$];   // bytes waiting in the FIFO
   logic       line_q[$];  // remaining tx samples of the frame in flight
   logic       prev_busy = 1'b0;
   logic       exp_tx = 1'b1, exp_busy = 1'b0, exp_irq = 1'b0;
   logic       exp_full = 1'b0, exp_empty = 1'b1, exp_ovf = 1'b0;

   int obs_busy = 0, obs_irq = 0, obs_ovf = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advance the model by one clock edge using the inputs present at that edge.
   task automatic model_step();
      int         sz;
      logic       do_pop;
      logic [7:0] b;
      int         d;
      logic       bv;
      if (rst) begin
         exp_q.delete();
         line_q.delete();
         prev_busy = 1'b0;
         exp_tx = 1'b1; exp_busy = 1'b0; exp_irq = 1'b0;
         exp_full = 1'b0; exp_empty = 1'b1; exp_ovf = 1'b0;
         return;
      end
      sz      = exp_q.size();
      do_pop  = (line_q.size() == 0) && (sz > 0);
      exp_irq = (line_q.size() == 0) && !do_pop && prev_busy;
      exp_ovf = i_tx_valid && (sz == DEPTH);
      if (do_pop) begin
         b = exp_q.pop_front();
         d = (clk_div == 0) ? 1 : int'(clk_div);
         for (int k = 0; k < 10; k++) begin
            bv = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
            repeat (d) line_q.push_back(bv);
         end
      end
      if (i_tx_valid && sz < DEPTH) exp_q.push_back(tx_data);
      if (line_q.size() > 0) begin
         exp_tx   = line_q.pop_front();
         exp_busy = 1'b1;
      end else begin
         exp_tx   = 1'b1;
         exp_busy = 1'b0;
      end
      prev_busy = exp_busy;
      exp_full  = (exp_q.size() == DEPTH);
      exp_empty = (exp_q.size() == 0);
   endtask

   // One clock: step the model at the edge, then compare outputs 1 time unit later.
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check("tx", tx, exp_tx);
      check("busy", busy, exp_busy);
      check("irq", irq, exp_irq);
      check("full", o_tx_full, exp_full);
      check("empty", o_tx_empty, exp_empty);
      check("overflow", o_tx_overflow, exp_ovf);
      obs_busy += int'(busy);
      obs_irq  += int'(irq);
      obs_ovf  += int'(o_tx_overflow);
   endtask

   // Driver helpers
   task automatic write_byte(input logic [7:0] b);
      i_tx_valid = 1'b1;
      tx_data    = b;
      tick();
      i_tx_valid = 1'b0;
   endtask

   task automatic drain();
      int g = 0;
      while ((line_q.size() > 0 || exp_q.size() > 0 || exp_busy || exp_irq) && g < 20000) begin
         tick();
         g++;
      end
      tick();
   endtask

   task automatic clear_obs();
      obs_busy = 0;
      obs_irq  = 0;
      obs_ovf  = 0;
   endtask

   initial begin
      // Reset state
      rst = 1'b1;
      tick();
      tick();
      check("rst_tx", tx, 1);
      check("rst_empty", o_tx_empty, 1);
      rst = 1'b0;
      tick();

      // 0xA5 at divider 4: 40 busy cycles, one irq
      clk_div = 32'd4;
      clear_obs();
      write_byte(8'hA5);
      drain();
      check("a5_busy_cycles", obs_busy, 40);
      check("a5_irq_count", obs_irq, 1);

      // 0x00 then 0xFF back to back at divider 3
      clk_div = 32'd3;
      clear_obs();
      write_byte(8'h00);
      write_byte(8'hFF);
      drain();
      check("b2b_busy_cycles", obs_busy, 60);
      check("b2b_irq_count", obs_irq, 1);

      // Overflow with the line stalled at divider 1000
      clk_div = 32'd1000;
      clear_obs();
      for (int i = 0; i < 10; i++) begin
         write_byte(8'(i + 16));
         if (i == 8) check("full_after_9th", o_tx_full, 1);
      end
      tick();
      check("ovf_count", obs_ovf, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();

      // Divider 0 and 1 both give a 10-cycle frame
      for (int dv = 0; dv < 2; dv++) begin
         clk_div = 32'(dv);
         clear_obs();
         write_byte(8'h3C);
         drain();
         check("div01_busy_cycles", obs_busy, 10);
         check("div01_irq_count", obs_irq, 1);
      end

      // Divider change mid-frame only affects the next frame
      clk_div = 32'd8;
      clear_obs();
      write_byte(8'h55);
      write_byte(8'h96);
      repeat (20) tick();
      clk_div = 32'd2;
      drain();
      check("divchg_busy_cycles", obs_busy, 100);
      check("divchg_irq_count", obs_irq, 1);

      // Reset during data bits with bytes queued
      clk_div = 32'd4;
      for (int i = 0; i < 4; i++) write_byte(8'(8'hE0 + i));
      repeat (12) tick();
      clear_obs();
      rst = 1'b1;
      tick();
      check("midrst_tx", tx, 1);
      check("midrst_busy", busy, 0);
      check("midrst_empty", o_tx_empty, 1);
      rst = 1'b0;
      repeat (50) tick();
      check("midrst_no_irq", obs_irq, 0);
      check("midrst_no_busy", obs_busy, 0);
      clear_obs();
      write_byte(8'hC3);
      drain();
      check("postrst_busy_cycles", obs_busy, 40);
      check("postrst_irq_count", obs_irq, 1);

      // Randomized traffic, divider changes and occasional resets
      for (int it = 0; it < 800; it++) begin
         rst        = ($urandom_range(0, 149) == 0);
         i_tx_valid = ($urandom_range(0, 3) == 0);
         tx_data    = 8'($urandom);
         if ($urandom_range(0, 19) == 0) clk_div = 32'($urandom_range(0, 4));
         tick();
      end
      rst = 1'b0;
      i_tx_valid = 1'b0;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
